// File: rtl/seq_mult_mem_top_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_mem_top_if
// Brief    : Start/busy/done handshake, address and read-port bundle for
//            seq_mult_mem_top.
// Revision : 1.0  initial release
// ============================================================================
interface seq_mult_mem_top_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
);
    logic                  start;
    logic [ADDR_W-1:0]     adr1_r;
    logic [ADDR_W-1:0]     adr2_r;
    logic [ADDR_W-1:0]     adr_ram;
    logic [ADDR_W-1:0]     rd_adr;
    logic [2*WIDTH-1:0]    result;
    logic                  busy;
    logic                  done;
    logic [3:0]            st_out;

    modport master (
        output start, adr1_r, adr2_r, adr_ram, rd_adr,
        input  result, busy, done, st_out
    );

    modport slave (
        input  start, adr1_r, adr2_r, adr_ram, rd_adr,
        output result, busy, done, st_out
    );
endinterface
`default_nettype wire

// File: rtl/seq_mult_mem_top.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_mem_top
// Brief    : ROM-fed sequential shift-add multiplier writing products to RAM,
//            with a registered read port. Optional MULT_SIGNED_EN macro
//            selects two's complement operands and product.
// Revision : 1.0  initial release
// ============================================================================
module seq_mult_mem_top #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    seq_mult_mem_top_if.slave bus
);
    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_MULT  = 4'd2,
        S_WRITE = 4'd3,
        S_DONE  = 4'd4
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_adr1;
    logic [ADDR_W-1:0]   r_adr2;
    logic [ADDR_W-1:0]   r_adr_wr;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2*WIDTH-1:0]  r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*WIDTH-1:0]  r_ram [c_DEPTH];
    logic [2*WIDTH-1:0]  r_result;

    logic [WIDTH-1:0]    w_rom_a;
    logic [WIDTH-1:0]    w_rom_b;
    logic [WIDTH-1:0]    w_op_a;
    logic [WIDTH-1:0]    w_op_b;
    logic [2*WIDTH-1:0]  w_wr_data;
    logic                w_wr_en;

    // Constant operand ROM: rom[a] = (3*a + 1) mod 2**WIDTH
    function automatic logic [WIDTH-1:0] f_rom(input logic [ADDR_W-1:0] adr);
        return WIDTH'(32'(adr) * 32'd3 + 32'd1);
    endfunction

    assign w_rom_a = f_rom(r_adr1);
    assign w_rom_b = f_rom(r_adr2);
    assign w_wr_en = (r_state == S_WRITE);

`ifdef MULT_SIGNED_EN
    logic r_neg;
    // Magnitudes go through the unsigned datapath; the most negative operand
    // maps to 2**(WIDTH-1), which still fits in WIDTH unsigned bits.
    assign w_op_a    = w_rom_a[WIDTH-1] ? (~w_rom_a + WIDTH'(1)) : w_rom_a;
    assign w_op_b    = w_rom_b[WIDTH-1] ? (~w_rom_b + WIDTH'(1)) : w_rom_b;
    assign w_wr_data = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
`else
    assign w_op_a    = w_rom_a;
    assign w_op_b    = w_rom_b;
    assign w_wr_data = r_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_adr1   <= '0;
            r_adr2   <= '0;
            r_adr_wr <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef MULT_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_adr1   <= bus.adr1_r;
                        r_adr2   <= bus.adr2_r;
                        r_adr_wr <= bus.adr_ram;
                        r_busy   <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_a     <= w_op_a;
                    r_b     <= w_op_b;
                    r_acc   <= '0;
                    r_cnt   <= '0;
`ifdef MULT_SIGNED_EN
                    r_neg   <= w_rom_a[WIDTH-1] ^ w_rom_b[WIDTH-1];
`endif
                    r_state <= S_MULT;
                end
                S_MULT: begin
                    // Always WIDTH iterations so latency is data independent
                    if (r_b[0]) begin
                        r_acc <= r_acc + ((2*WIDTH)'(r_a) << r_cnt);
                    end
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Product RAM; the read samples the pre-write word on a same-address write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_ram[i] <= '0;
            end
            r_result <= '0;
        end else begin
            if (w_wr_en) begin
                r_ram[r_adr_wr] <= w_wr_data;
            end
            r_result <= r_ram[bus.rd_adr];
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.st_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_mem_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_mem_top
// Brief    : Self-checking bench for seq_mult_mem_top against a reference
//            model of ROM contents, products and RAM state.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_mult_mem_top;
    localparam int W     = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [2*W-1:0] ref_ram [DEPTH];

    seq_mult_mem_top_if #(.WIDTH(W), .ADDR_W(AW)) io ();

    seq_mult_mem_top #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (io)
    );

    always #5 clk = ~clk;

    function automatic int rom_val(input int a);
        return (3 * a + 1) % (1 << W);
    endfunction

    function automatic logic [2*W-1:0] prod_m(input int a1, input int a2);
        int x;
        int y;
        x = rom_val(a1);
        y = rom_val(a2);
`ifdef MULT_SIGNED_EN
        if (x >= (1 << (W - 1))) x -= (1 << W);
        if (y >= (1 << (W - 1))) y -= (1 << W);
`endif
        return (2*W)'(x * y);
    endfunction

    // Expected state code c cycles after start was accepted
    function automatic logic [3:0] st_exp(input int c);
        if (c == 1) return 4'd1;
        if (c >= 2 && c <= W + 1) return 4'd2;
        if (c == W + 2) return 4'd3;
        if (c == W + 3) return 4'd4;
        return 4'd0;
    endfunction

    task automatic read_word(input int adr, output logic [2*W-1:0] val);
        @(negedge clk);
        io.rd_adr = AW'(adr);
        @(negedge clk);
        val = io.result;
    endtask

    task automatic do_op(input int a1, input int a2, input int ar,
                         input bit noisy, input bit rbw);
        logic [2*W-1:0] old_w;
        logic [2*W-1:0] new_w;
        old_w = ref_ram[ar];
        new_w = prod_m(a1, a2);
        @(negedge clk);
        io.start   = 1'b1;
        io.adr1_r  = AW'(a1);
        io.adr2_r  = AW'(a2);
        io.adr_ram = AW'(ar);
        if (rbw) io.rd_adr = AW'(ar);
        @(posedge clk);
        #1 io.start = 1'b0;
        for (int c = 1; c <= W + 5; c++) begin
            @(negedge clk);
            checks++;
            if (io.st_out !== st_exp(c)) begin
                errors++;
                $display("FAIL op_st_out cyc %0d: got %0d expected %0d", c, io.st_out, st_exp(c));
            end
            checks++;
            if (io.busy !== (c <= W + 3)) begin
                errors++;
                $display("FAIL op_busy cyc %0d: got %0b expected %0b", c, io.busy, (c <= W + 3));
            end
            checks++;
            if (io.done !== (c == W + 3)) begin
                errors++;
                $display("FAIL op_done cyc %0d: got %0b expected %0b", c, io.done, (c == W + 3));
            end
            if (rbw && c == W + 3) begin
                checks++;
                if (io.result !== old_w) begin
                    errors++;
                    $display("FAIL rbw_old: got %0h expected %0h", io.result, old_w);
                end
            end
            if (rbw && c == W + 4) begin
                checks++;
                if (io.result !== new_w) begin
                    errors++;
                    $display("FAIL rbw_new: got %0h expected %0h", io.result, new_w);
                end
            end
            if (noisy) begin
                io.start = (c >= 2 && c <= W + 2);
                if (io.start) begin
                    io.adr1_r  = AW'($urandom_range(0, DEPTH - 1));
                    io.adr2_r  = AW'($urandom_range(0, DEPTH - 1));
                    io.adr_ram = AW'($urandom_range(0, DEPTH - 1));
                end
            end
        end
        io.start = 1'b0;
        ref_ram[ar] = new_w;
    endtask

    task automatic sweep_ram(input string tag);
        logic [2*W-1:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            read_word(a, v);
            checks++;
            if (v !== ref_ram[a]) begin
                errors++;
                $display("FAIL %s ram[%0d]: got %0h expected %0h", tag, a, v, ref_ram[a]);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        io.start   = 1'b0;
        io.adr1_r  = '0;
        io.adr2_r  = '0;
        io.adr_ram = '0;
        io.rd_adr  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (io.st_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_st_out: got %0d expected 0", io.st_out);
        end
        checks++;
        if (io.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b expected 0", io.busy);
        end
        checks++;
        if (io.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %0b expected 0", io.done);
        end
        for (int a = 0; a < DEPTH; a++) ref_ram[a] = '0;
        sweep_ram("reset");
    endtask

    task automatic test_basic();
        logic [2*W-1:0] v;
        do_op(1, 3, 2, 1'b0, 1'b0);
        read_word(2, v);
        checks++;
        if (v !== ref_ram[2]) begin
            errors++;
            $display("FAIL basic_product: got %0h expected %0h", v, ref_ram[2]);
        end
    endtask

    task automatic test_boundaries();
        do_op(4, 4, 3, 1'b0, 1'b0);
        do_op(5, 7, 6, 1'b0, 1'b0);
        do_op(4, 2, 0, 1'b0, 1'b0);
        do_op(3, 3, 5, 1'b0, 1'b0);
        sweep_ram("boundary");
    endtask

    task automatic test_ignore_start();
        do_op(2, 6, 4, 1'b1, 1'b0);
        sweep_ram("ignore_start");
    endtask

    task automatic test_random();
        repeat (6) begin
            do_op(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        sweep_ram("random");
    endtask

    task automatic test_read_before_write();
        do_op(1, 3, 7, 1'b0, 1'b0);
        do_op(4, 4, 7, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        int ar;
        int p;
        a1 = int'($urandom_range(0, DEPTH - 1));
        a2 = int'($urandom_range(0, DEPTH - 1));
        ar = int'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
        io.start   = 1'b1;
        io.adr1_r  = AW'(a1);
        io.adr2_r  = AW'(a2);
        io.adr_ram = AW'(ar);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            p = c % (W + 4);
            checks++;
            if (io.st_out !== st_exp(p)) begin
                errors++;
                $display("FAIL b2b_st_out cyc %0d: got %0d expected %0d", c, io.st_out, st_exp(p));
            end
            checks++;
            if (io.done !== (p == W + 3)) begin
                errors++;
                $display("FAIL b2b_done cyc %0d: got %0b expected %0b", c, io.done, (p == W + 3));
            end
            checks++;
            if (io.busy !== (p != 0)) begin
                errors++;
                $display("FAIL b2b_busy cyc %0d: got %0b expected %0b", c, io.busy, (p != 0));
            end
            if (c == 20) io.start = 1'b0;
        end
        ref_ram[ar] = prod_m(a1, a2);
        sweep_ram("b2b");
    endtask

    task automatic test_reset_mid();
        do_op(1, 3, 1, 1'b0, 1'b0);
        sweep_ram("pre_abort");
        @(negedge clk);
        io.start   = 1'b1;
        io.adr1_r  = AW'(2);
        io.adr2_r  = AW'(2);
        io.adr_ram = AW'(1);
        @(posedge clk);
        #1 io.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) rst = 1'b1;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (io.st_out !== 4'd0) begin
            errors++;
            $display("FAIL abort_st_out: got %0d expected 0", io.st_out);
        end
        checks++;
        if (io.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %0b expected 0", io.busy);
        end
        for (int c = 6; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (io.done !== 1'b0) begin
                errors++;
                $display("FAIL abort_done cyc %0d: got %0b expected 0", c, io.done);
            end
        end
        for (int a = 0; a < DEPTH; a++) ref_ram[a] = '0;
        sweep_ram("abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_random();
        test_read_before_write();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
